// File: rtl/time_display.sv
`default_nettype none
// ============================================================================
//  Module   : time_display
//  Purpose  : Chronometer front end for an 8-digit multiplexed 7-segment
//             display showing H.MM.SS.mmm. Once per scan frame it snapshots
//             the counter, converts it to BCD and scans the result onto an,
//             seg and dp.
//  Revision : 1.0  initial release
// ============================================================================
module time_display #(
   parameter int SCAN_DIV = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  hours,
   input  logic [5:0]  minutes,
   input  logic [5:0]  seconds,
   input  logic [9:0]  milliseconds,
   input  logic        hold,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_SHIFT   = 2'd2;
   localparam logic [1:0] ST_LOAD    = 2'd3;

   localparam logic [9:0] PRESC_LAST = 10'(SCAN_DIV - 1);
   localparam logic [3:0] LAST_SHIFT = 4'd9;

   logic [9:0]  presc_q, presc_d;
   logic [2:0]  idx_q, idx_d;
   logic        adv_q, adv_d;
   logic        frame_start;
   logic [1:0]  state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [3:0]  hrs_q, hrs_d;
   logic [9:0]  min_bin_q, min_bin_d;
   logic [9:0]  sec_bin_q, sec_bin_d;
   logic [9:0]  ms_bin_q, ms_bin_d;
   logic [7:0]  min_bcd_q, min_bcd_d;
   logic [7:0]  sec_bcd_q, sec_bcd_d;
   logic [11:0] ms_bcd_q, ms_bcd_d;
   logic [31:0] disp_q, disp_d;
   logic [7:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;

   // One double-dabble step for a two-digit result: add 3 to nibbles >= 5, then shift.
   function automatic logic [17:0] dd_step2(input logic [7:0] bcd, input logic [9:0] bin);
      logic [7:0]  adj;
      logic [17:0] v;
      adj = bcd;
      if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
      if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
      v = {adj, bin};
      v = v << 1;
      return v;
   endfunction

   // Three-digit variant; the thousands carry simply falls off the top.
   function automatic logic [21:0] dd_step3(input logic [11:0] bcd, input logic [9:0] bin);
      logic [11:0] adj;
      logic [21:0] v;
      adj = bcd;
      if (adj[3:0]  >= 4'd5) adj[3:0]  = adj[3:0]  + 4'd3;
      if (adj[7:4]  >= 4'd5) adj[7:4]  = adj[7:4]  + 4'd3;
      if (adj[11:8] >= 4'd5) adj[11:8] = adj[11:8] + 4'd3;
      v = {adj, bin};
      v = v << 1;
      return v;
   endfunction

   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Scan prescaler and digit index; a wrap from digit 0 to 7 marks the frame start.
   always_comb begin
      presc_d     = presc_q + 10'd1;
      idx_d       = idx_q;
      adv_d       = 1'b0;
      frame_start = 1'b0;
      if (presc_q == PRESC_LAST) begin
         presc_d     = '0;
         idx_d       = idx_q - 3'd1;
         adv_d       = 1'b1;
         frame_start = (idx_q == 3'd0);
      end
   end

   // Converter: snapshot on the frame-start edge, 10 dabble steps, then load the display.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      hrs_d     = hrs_q;
      min_bin_d = min_bin_q;
      sec_bin_d = sec_bin_q;
      ms_bin_d  = ms_bin_q;
      min_bcd_d = min_bcd_q;
      sec_bcd_d = sec_bcd_q;
      ms_bcd_d  = ms_bcd_q;
      disp_d    = disp_q;
      case (state_q)
         ST_IDLE: begin
            if (frame_start && !hold) begin
               hrs_d     = hours;
               min_bin_d = {4'b0000, minutes};
               sec_bin_d = {4'b0000, seconds};
               ms_bin_d  = milliseconds;
               min_bcd_d = '0;
               sec_bcd_d = '0;
               ms_bcd_d  = '0;
               state_d   = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            bit_cnt_d = '0;
            state_d   = ST_SHIFT;
         end
         ST_SHIFT: begin
            {min_bcd_d, min_bin_d} = dd_step2(min_bcd_q, min_bin_q);
            {sec_bcd_d, sec_bin_d} = dd_step2(sec_bcd_q, sec_bin_q);
            {ms_bcd_d,  ms_bin_d}  = dd_step3(ms_bcd_q,  ms_bin_q);
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_SHIFT) state_d = ST_LOAD;
         end
         default: begin
            disp_d  = {hrs_q, min_bcd_q, sec_bcd_q, ms_bcd_q};
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output drivers refresh only on the edge after an index change, so an/seg/dp move together.
   always_comb begin
      an_d  = an_q;
      seg_d = seg_q;
      dp_d  = dp_q;
      if (adv_q) begin
         an_d  = ~(8'd1 << idx_q);
         seg_d = seg_enc(disp_q[{idx_q, 2'b00} +: 4]);
         dp_d  = !((idx_q == 3'd7) || (idx_q == 3'd5) || (idx_q == 3'd3));
      end
   end

   // State registers with asynchronous reset; reset also discards any conversion in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q   <= '0;
         idx_q     <= '0;
         adv_q     <= 1'b0;
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         hrs_q     <= '0;
         min_bin_q <= '0;
         sec_bin_q <= '0;
         ms_bin_q  <= '0;
         min_bcd_q <= '0;
         sec_bcd_q <= '0;
         ms_bcd_q  <= '0;
         disp_q    <= '0;
         an_q      <= 8'hFF;
         seg_q     <= 7'h7F;
         dp_q      <= 1'b1;
      end else begin
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         adv_q     <= adv_d;
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         hrs_q     <= hrs_d;
         min_bin_q <= min_bin_d;
         sec_bin_q <= sec_bin_d;
         ms_bin_q  <= ms_bin_d;
         min_bcd_q <= min_bcd_d;
         sec_bcd_q <= sec_bcd_d;
         ms_bcd_q  <= ms_bcd_d;
         disp_q    <= disp_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule
`default_nettype wire

// File: doc/time_display.md
TIME_DISPLAY -- requirements
Module: time_display

Interface
REQ-001 SCAN_DIV, default 2, clk cycles each digit stays active; legal range 2..1023.
REQ-002 clk  input  1  single clock, rising edge; same clock that drives the chronometer counter.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 hours  input  4  elapsed hours from the counter stage.
REQ-005 minutes  input  6  elapsed minutes from the counter stage.
REQ-006 seconds  input  6  elapsed seconds from the counter stage.
REQ-007 milliseconds  input  10  elapsed milliseconds from the counter stage.
REQ-008 hold  input  1  level; 1 = freeze displayed value (lap), 0 = live.
REQ-009 an  output  8  digit enables, active-low, one-hot-low; an[0] = rightmost digit.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point, active-low.

Function
REQ-012 Digit map: 7 = hours (hex 0-F); 6,5 = minutes tens/units; 4,3 = seconds tens/units; 2,1,0 = ms hundreds/tens/units.
REQ-013 Scan: prescaler counts 0..SCAN_DIV-1; on terminal count, digit index advances 7->6->...->0->7 (decrement, wrap 0->7).
REQ-014 Frame start = cycle on which the index wraps from 0 to 7; with hold=0 it raises a capture request.
REQ-015 Converter FSM states: IDLE, CAPTURE, SHIFT, LOAD.
REQ-016 IDLE->CAPTURE on capture request; CAPTURE registers all four inputs in one cycle (snapshot).
REQ-017 SHIFT: 10 cycles of parallel double-dabble on minutes, seconds, milliseconds (6-bit operands zero-extended to 10 bits); add-3 to every BCD nibble >=5 before each shift.
REQ-018 LOAD: one cycle; writes hours and the 7 decimal digits to the display registers; then IDLE.
REQ-019 Latency: display registers update exactly 12 cycles after the frame-start cycle (CAPTURE +1, SHIFT +2..+11, LOAD +12).
REQ-020 Conversion always finishes within one frame (8*SCAN_DIV >= 16 > 12); a capture request is never lost or queued.
REQ-021 Out-of-range inputs (minutes/seconds 60-63, ms 1000-1023) display their true decimal value; ms thousands digit is discarded (1023 -> "023").
REQ-022 hold=1 at frame start: no capture; display registers keep their value; scanning continues.
REQ-023 hold changes mid-conversion do not abort it; hold is sampled only at frame start.
REQ-024 Outputs registered: an, seg, dp change only on the clk edge following an index change, all three together.
REQ-025 Segment encoding (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-026 dp low on digits 7, 5, 3 (H.MM.SS.mmm); high elsewhere.

Reset
REQ-027 Reset asserted: an=8'hFF, seg=7'h7F, dp=1, display registers 0, prescaler 0, index 0, FSM IDLE, immediately (no clock needed).
REQ-028 After reset release: first advance after SCAN_DIV cycles is a wrap (0->7), so the first capture occurs then; digits show 0 until its LOAD.
REQ-029 Reset mid-conversion discards the snapshot; no partial LOAD.

Verification
REQ-030 hours=1, minutes=23, seconds=45, ms=678, hold=0, run 2 frames -> digits 7..0 seg = 1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000; dp low on 7,5,3.
REQ-031 Frame start with inputs 0:00:00.000, inputs change to 0:00:01.500 on the next cycle -> display shows 0:00:00.000 (snapshot), new value at the following frame.
REQ-032 hold=1 after 2:10:05.007 displayed, inputs advance 3 frames -> display unchanged; hold=0 -> current value appears 12 cycles after the next frame start.
REQ-033 hours=15, minutes=63, seconds=60, ms=1023 -> digits "F 63 60 023".
REQ-034 Reset pulse of 1 cycle during SHIFT -> an=FF, seg=7F at once; after release, prior digits gone (all 0) until the next capture loads the current input.
REQ-035 Continuous check, SCAN_DIV=2 and 5: exactly one an bit low at all times after the first advance; each digit active SCAN_DIV cycles; scan order 7..0.
